// File: rtl/synth_bank.sv
// Polyphase synthesis bank: 8 channels x 128-tap delay lines, multiplied against a packed
// coefficient ROM (two taps per word) and accumulated into one output sample per strobe.
module synth_bank #(
    parameter int unsigned OUT_LSB  = 16,
    parameter bit          SATURATE = 1'b1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic signed [15:0] datain0,
    input  logic signed [15:0] datain1,
    input  logic signed [15:0] datain2,
    input  logic signed [15:0] datain3,
    input  logic signed [15:0] datain4,
    input  logic signed [15:0] datain5,
    input  logic signed [15:0] datain6,
    input  logic signed [15:0] datain7,
    input  logic               din_enable,
    output logic [5:0]         coeffaddress,
    input  logic [35:0]        coeff0,
    input  logic [35:0]        coeff1,
    input  logic [35:0]        coeff2,
    input  logic [35:0]        coeff3,
    input  logic [35:0]        coeff4,
    input  logic [35:0]        coeff5,
    input  logic [35:0]        coeff6,
    input  logic [35:0]        coeff7,
    output logic signed [15:0] dataout,
    output logic               dout_valid,
    output logic               busy,
    output logic               overrun
);

    localparam int unsigned AccW = 48;
    localparam int unsigned Taps = 128;
    localparam logic signed [AccW-1:0] MaxOut = AccW'(32767);
    localparam logic signed [AccW-1:0] MinOut = -AccW'(32768);

    typedef enum logic [1:0] {IDLE, SHIFT, MAC, OUT} state_e;

    state_e state_q, state_d;

    logic        [6:0]      cnt_q;
    logic signed [15:0]     din   [8];
    logic        [35:0]     coeff [8];
    logic signed [15:0]     dl_q  [8][Taps];
    logic signed [33:0]     prod_q [16];
    logic signed [33:0]     prod_d [16];
    logic signed [AccW-1:0] acc_q;
    logic signed [AccW-1:0] prod_sum;
    logic signed [AccW-1:0] acc_shift;
    logic signed [15:0]     out_val;
    logic        [5:0]      tap_pair;
    logic                   start;
    logic                   prod_en;
    logic                   acc_en;

    assign din[0] = datain0;
    assign din[1] = datain1;
    assign din[2] = datain2;
    assign din[3] = datain3;
    assign din[4] = datain4;
    assign din[5] = datain5;
    assign din[6] = datain6;
    assign din[7] = datain7;

    assign coeff[0] = coeff0;
    assign coeff[1] = coeff1;
    assign coeff[2] = coeff2;
    assign coeff[3] = coeff3;
    assign coeff[4] = coeff4;
    assign coeff[5] = coeff5;
    assign coeff[6] = coeff6;
    assign coeff[7] = coeff7;

    assign busy  = (state_q != IDLE);
    assign start = (state_q == IDLE) && din_enable;

    // cnt_q = edges since the start strobe; ROM data for pair k arrives when cnt_q = k+1.
    assign tap_pair = cnt_q[5:0] - 6'd1;
    assign prod_en  = (state_q == MAC) && (cnt_q <= 7'd64);
    assign acc_en   = (state_q == MAC) && (cnt_q >= 7'd2);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (din_enable) state_d = SHIFT;
            SHIFT:   state_d = MAC;
            MAC:     if (cnt_q == 7'd65) state_d = OUT;
            OUT:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        for (int ch = 0; ch < 8; ch++) begin
            prod_d[2*ch]   = 34'(dl_q[ch][{tap_pair, 1'b0}]) * 34'($signed(coeff[ch][17:0]));
            prod_d[2*ch+1] = 34'(dl_q[ch][{tap_pair, 1'b1}]) * 34'($signed(coeff[ch][35:18]));
        end
    end

    always_comb begin
        prod_sum = '0;
        for (int i = 0; i < 16; i++) begin
            prod_sum = prod_sum + AccW'(prod_q[i]);
        end
    end

    always_comb begin
        acc_shift = acc_q >>> OUT_LSB;
        out_val   = acc_q[OUT_LSB +: 16];
        if (SATURATE) begin
            if (acc_shift > MaxOut) begin
                out_val = 16'sh7fff;
            end else if (acc_shift < MinOut) begin
                out_val = 16'sh8000;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q        <= '0;
            coeffaddress <= '0;
            acc_q        <= '0;
            dataout      <= '0;
            dout_valid   <= 1'b0;
            overrun      <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                prod_q[i] <= '0;
            end
            for (int ch = 0; ch < 8; ch++) begin
                for (int t = 0; t < Taps; t++) begin
                    dl_q[ch][t] <= '0;
                end
            end
        end else begin
            if (start) begin
                cnt_q        <= '0;
                coeffaddress <= '0;
                acc_q        <= '0;
                for (int ch = 0; ch < 8; ch++) begin
                    for (int t = Taps - 1; t > 0; t--) begin
                        dl_q[ch][t] <= dl_q[ch][t-1];
                    end
                    dl_q[ch][0] <= din[ch];
                end
            end else if (busy) begin
                cnt_q <= cnt_q + 7'd1;
                if (coeffaddress != 6'd63) begin
                    coeffaddress <= coeffaddress + 6'd1;
                end
                if (acc_en) begin
                    acc_q <= acc_q + prod_sum;
                end
            end

            if (prod_en) begin
                for (int i = 0; i < 16; i++) begin
                    prod_q[i] <= prod_d[i];
                end
            end

            dout_valid <= (state_q == OUT);
            if (state_q == OUT) begin
                dataout <= out_val;
            end

            // A strobe on the OUT edge still counts as arriving while busy.
            if (din_enable && busy) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_synth_bank.sv
// Bench for synth_bank: coefficient ROM model plus a history-based reference of the
// filter output, with directed and randomized strobes.
module tb_synth_bank;

    localparam int OutLsb = 16;

    logic               clock = 1'b0;
    logic               reset;
    logic signed [15:0] din_v [8];
    logic               din_enable;
    logic [5:0]         coeffaddress;
    logic [35:0]        coeff_v [8];
    logic signed [15:0] dataout;
    logic               dout_valid;
    logic               busy;
    logic               overrun;

    int n_checks = 0;
    int n_errors = 0;

    logic [35:0] rom  [8][64];
    longint      hist [8][128];

    always #5 clock = ~clock;

    always @(posedge clock) begin
        for (int i = 0; i < 8; i++) begin
            coeff_v[i] <= rom[i][coeffaddress];
        end
    end

    synth_bank dut (
        .clock        (clock),
        .reset        (reset),
        .datain0      (din_v[0]),
        .datain1      (din_v[1]),
        .datain2      (din_v[2]),
        .datain3      (din_v[3]),
        .datain4      (din_v[4]),
        .datain5      (din_v[5]),
        .datain6      (din_v[6]),
        .datain7      (din_v[7]),
        .din_enable   (din_enable),
        .coeffaddress (coeffaddress),
        .coeff0       (coeff_v[0]),
        .coeff1       (coeff_v[1]),
        .coeff2       (coeff_v[2]),
        .coeff3       (coeff_v[3]),
        .coeff4       (coeff_v[4]),
        .coeff5       (coeff_v[5]),
        .coeff6       (coeff_v[6]),
        .coeff7       (coeff_v[7]),
        .dataout      (dataout),
        .dout_valid   (dout_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    task automatic check(input string tag, input longint obs, input longint exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Filter output straight from its definition: sum of sample x coefficient over all taps.
    function automatic longint model_out();
        longint      acc;
        logic [17:0] hv;
        acc = 0;
        for (int ch = 0; ch < 8; ch++) begin
            for (int t = 0; t < 128; t++) begin
                hv = (t % 2 == 1) ? rom[ch][t/2][35:18] : rom[ch][t/2][17:0];
                acc += hist[ch][t] * longint'($signed(hv));
            end
        end
        acc = acc >>> OutLsb;
        if (acc > 32767) acc = 32767;
        if (acc < -32768) acc = -32768;
        return acc;
    endfunction

    task automatic push_hist();
        for (int ch = 0; ch < 8; ch++) begin
            for (int t = 127; t > 0; t--) hist[ch][t] = hist[ch][t-1];
            hist[ch][0] = longint'(din_v[ch]);
        end
    endtask

    task automatic clear_hist();
        for (int ch = 0; ch < 8; ch++)
            for (int t = 0; t < 128; t++) hist[ch][t] = 0;
    endtask

    task automatic clear_rom();
        for (int ch = 0; ch < 8; ch++)
            for (int a = 0; a < 64; a++) rom[ch][a] = '0;
    endtask

    task automatic set_din(input int ch, input int val);
        for (int i = 0; i < 8; i++) din_v[i] = '0;
        din_v[ch] = 16'(val);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        clear_hist();
    endtask

    // One accepted strobe, then wait (bounded) for the result and check timing and value.
    task automatic strobe_and_check(input string tag);
        longint exp;
        int     cyc;
        bit     seen;
        push_hist();
        exp = model_out();
        @(negedge clock);
        din_enable = 1'b1;
        @(posedge clock);
        #1;
        din_enable = 1'b0;
        check({tag, "_busy_start"}, busy, 1);
        check({tag, "_addr_start"}, coeffaddress, 0);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 100) begin
            @(posedge clock);
            #1;
            cyc++;
            if (cyc == 20) check({tag, "_addr20"}, coeffaddress, 20);
            if (cyc == 66) check({tag, "_addr_hold"}, coeffaddress, 63);
            if (dout_valid) seen = 1'b1;
        end
        check({tag, "_latency"}, cyc, 67);
        check({tag, "_data"}, dataout, exp);
        check({tag, "_busy_end"}, busy, 0);
        @(posedge clock);
        #1;
        check({tag, "_valid_pulse"}, dout_valid, 0);
        check({tag, "_data_hold"}, dataout, exp);
    endtask

    initial begin
        longint exp;
        int     pulses;
        int     lat;
        longint val;

        reset      = 1'b1;
        din_enable = 1'b0;
        for (int i = 0; i < 8; i++) din_v[i] = '0;
        clear_rom();
        clear_hist();
        #1 reset = 1'b0;
        #1;
        check("rst_dataout", dataout, 0);
        check("rst_valid", dout_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_overrun", overrun, 0);
        check("rst_addr", coeffaddress, 0);
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(posedge clock);

        // Impulse through the even tap of channel 0
        rom[0][0][17:0] = 18'd65536;
        set_din(0, 1000);
        strobe_and_check("impulse");
        set_din(0, 0);
        strobe_and_check("impulse_zero");

        // Odd tap of channel 3: the sample surfaces one strobe later
        clear_rom();
        rom[3][0][35:18] = 18'd65536;
        set_din(3, -500);
        strobe_and_check("odd_first");
        set_din(3, 0);
        strobe_and_check("odd_second");

        // Random coefficients and samples
        for (int ch = 0; ch < 8; ch++)
            for (int a = 0; a < 64; a++)
                rom[ch][a] = {18'(int'($urandom_range(0, 4095)) - 2048),
                              18'(int'($urandom_range(0, 4095)) - 2048)};
        for (int s = 0; s < 6; s++) begin
            for (int ch = 0; ch < 8; ch++) din_v[ch] = 16'($urandom);
            strobe_and_check("random");
        end

        // Saturation, positive then negative, each from a cleared history
        for (int ch = 0; ch < 8; ch++)
            for (int a = 0; a < 64; a++) rom[ch][a] = {18'd131071, 18'd131071};
        do_reset();
        for (int ch = 0; ch < 8; ch++) din_v[ch] = 16'sd32767;
        for (int s = 0; s < 128; s++) strobe_and_check("sat_pos");
        check("sat_pos_const", dataout, 32767);
        do_reset();
        for (int ch = 0; ch < 8; ch++) din_v[ch] = -16'sd32768;
        for (int s = 0; s < 128; s++) strobe_and_check("sat_neg");
        check("sat_neg_const", dataout, -32768);

        // Overrun: second strobe 30 cycles in is dropped
        clear_rom();
        rom[0][0][17:0] = 18'd65536;
        set_din(0, 1000);
        push_hist();
        exp = model_out();
        @(negedge clock);
        din_enable = 1'b1;
        @(posedge clock);
        #1;
        din_enable = 1'b0;
        check("ovr_before", overrun, 0);
        repeat (29) @(posedge clock);
        @(negedge clock);
        din_v[0]   = 16'sd7777;
        din_enable = 1'b1;
        @(posedge clock);
        #1;
        din_enable = 1'b0;
        check("ovr_set", overrun, 1);
        pulses = 0;
        lat    = 0;
        val    = 0;
        for (int i = 31; i <= 130; i++) begin
            @(posedge clock);
            #1;
            if (dout_valid) begin
                pulses++;
                lat = i;
                val = longint'(dataout);
            end
        end
        check("ovr_pulses", pulses, 1);
        check("ovr_latency", lat, 67);
        check("ovr_data", val, exp);
        check("ovr_sticky", overrun, 1);

        // Reset in the middle of MAC
        set_din(0, 1000);
        @(negedge clock);
        din_enable = 1'b1;
        @(posedge clock);
        #1;
        din_enable = 1'b0;
        repeat (41) @(posedge clock);
        #2 reset = 1'b0;
        #1;
        check("mid_rst_dataout", dataout, 0);
        check("mid_rst_valid", dout_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_overrun", overrun, 0);
        check("mid_rst_addr", coeffaddress, 0);
        @(negedge clock);
        reset = 1'b1;
        clear_hist();
        pulses = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clock);
            #1;
            if (dout_valid) pulses++;
        end
        check("mid_rst_no_valid", pulses, 0);
        set_din(0, 1000);
        strobe_and_check("post_rst_impulse");
        set_din(0, 0);
        strobe_and_check("post_rst_zero");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
